up_dn_cntr_param: RTL and testbench
===================================

Name: up_dn_cntr_param

Overview:
- Parametrised successor of the team's 4-bit up/down counter with load and start/stop.
- Adds configurable width and count range (MIN_VAL..MAX_VAL, e.g. decade or modulo-N), run-time mode selection (wrap, saturate, one-shot), a terminal-count flag and a run-control FSM.
- Used as a general-purpose event/timer counter in control datapaths.

Parameters:
- WIDTH, 8, counter width in bits.
- MAX_VAL, 255, upper count bound; must satisfy MIN_VAL < MAX_VAL <= 2^WIDTH-1.
- MIN_VAL, 0, lower count bound.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- load_en  input  1  load request, 1 = load load_data this edge.
- load_data  input  WIDTH  parallel load value.
- up_dnb  input  1  direction, 1 = up, 0 = down.
- start_stop_b  input  1  run request level, 1 = start/run, 0 = stop.
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- cnt  output  WIDTH  registered count value.
- tc  output  1  terminal count, combinational: up_dnb ? (cnt==MAX_VAL) : (cnt==MIN_VAL).
- running  output  1  registered, 1 when FSM in RUN.
- done  output  1  registered, 1 when FSM in DONE.

Behaviour:
- Reset (reset==0 at posedge): cnt=MIN_VAL, state=IDLE, running=0, done=0. Overrides all other inputs.
- Priority per edge: reset > load > count > hold.
- Load: cnt <= load_data clamped to [MIN_VAL, MAX_VAL]; allowed in any state; takes effect the edge it is sampled; suppresses counting that edge; if state==DONE, state -> IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start_stop_b==1 (no count on the transition edge; first count on the following edge).
  - RUN -> IDLE when start_stop_b==0 (no count on that edge; cnt holds).
  - RUN -> DONE in one-shot mode when the edge's count result equals the terminal value for the current direction.
  - DONE -> IDLE when start_stop_b==0 or on load. DONE holds cnt, start_stop_b==1 does not restart it.
- Counting, only in RUN and only when load_en==0, one step per clock:
  - Up, cnt<MAX_VAL: cnt+1. Up, cnt==MAX_VAL: wrap -> MIN_VAL; saturate -> hold; one-shot -> hold (already DONE).
  - Down mirrors this about MIN_VAL: wrap -> MAX_VAL.
- Arithmetic is strictly within [MIN_VAL, MAX_VAL]; no out-of-range value ever appears on cnt, including with non-power-of-2 ranges.
- up_dnb or mode change mid-run is applied on the next edge; no glitch state.
- One-shot started with cnt already at the terminal value: first RUN edge holds cnt and moves to DONE.
- Reset mid-run or mid-DONE: immediate return to reset values on that edge.

Optional Feature:
- Macro UP_DN_CNTR_WRAP_FLAG_EN.
- Defined: adds output wrap_flag (1 bit, registered, reset 0). It is sticky-set on any wrap event (MAX->MIN up or MIN->MAX down, wrap mode only) and cleared only by load or reset. If set and cleared on the same edge, load wins (cleared).
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=4, MAX_VAL=9, MIN_VAL=0, mode=00, up: release reset, start_stop_b=1 -> running=1 next edge, cnt 0,1,..,9,0; tc=1 while cnt==9.
- Same, down, mode=01, load_data=2 with load_en pulse -> cnt 2,1,0,0,0; saturates at 0; tc=1 from cnt==0.
- mode=10 up from load 7 -> cnt 8,9 then done=1, running=0, cnt holds 9 with start_stop_b=1; drop start_stop_b -> IDLE, done=0.
- load_data=12 (out of range) -> cnt=9; load_en and counting on the same edge -> cnt=loaded value, no increment.
- start_stop_b=0 at cnt=5 -> cnt holds 5, running=0; reset=0 mid-run at cnt=6 -> cnt=0, running=0, done=0 on that edge.
- UP_DN_CNTR_WRAP_FLAG_EN defined: wrap 9->0 -> wrap_flag=1 and stays set; then load -> wrap_flag=0.

Source files
------------

// File: rtl/up_dn_cntr_param.sv
// Parametrised up/down counter: load, wrap/saturate/one-shot modes, run FSM.
// Optional sticky wrap_flag output when UP_DN_CNTR_WRAP_FLAG_EN is defined.
module up_dn_cntr_param #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 255,
  parameter int MIN_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             up_dnb,
  input  logic             start_stop_b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             running,
  output logic             done
`ifdef UP_DN_CNTR_WRAP_FLAG_EN
  ,
  output logic             wrap_flag
`endif
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ld_val, term_val;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             wrap_mode, os_mode;
  logic             count_en, at_term;

  always_comb begin
    wrap_mode = (mode == 2'b00) || (mode == 2'b11);
    os_mode   = (mode == 2'b10);
    term_val  = up_dnb ? MAX_C : MIN_C;
    at_term   = (cnt_q == term_val);
    count_en  = (state_q == RUN) && start_stop_b && !load_en;
  end

  // Clamp loads so cnt never leaves [MIN_VAL, MAX_VAL].
  always_comb begin
    ld_val = load_data;
    unique case (1'b1)
      (load_data <= MIN_C): ld_val = MIN_C;
      (load_data >= MAX_C): ld_val = MAX_C;
      default:              ld_val = load_data;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_en) begin
      cnt_d = ld_val;
    end else if (count_en) begin
      if (!at_term) begin
        cnt_d = up_dnb ? cnt_q + ONE_C : cnt_q - ONE_C;
      end else if (wrap_mode) begin
        cnt_d = up_dnb ? MIN_C : MAX_C;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_stop_b) state_d = RUN;
      end
      RUN: begin
        if (!start_stop_b) begin
          state_d = IDLE;
        end else if (count_en && os_mode &&
                     cnt_d == term_val) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start_stop_b || load_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= MIN_C;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign cnt     = cnt_q;
  assign tc      = at_term;
  assign running = running_q;
  assign done    = done_q;

`ifdef UP_DN_CNTR_WRAP_FLAG_EN
  logic wrap_flag_q, wrap_flag_d;
  logic wrap_evt;

  assign wrap_evt = count_en && at_term && wrap_mode;

  // Load clears even when a wrap would set on the same edge.
  always_comb begin
    wrap_flag_d = wrap_flag_q;
    if (load_en)       wrap_flag_d = 1'b0;
    else if (wrap_evt) wrap_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) wrap_flag_q <= 1'b0;
    else        wrap_flag_q <= wrap_flag_d;
  end

  assign wrap_flag = wrap_flag_q;
`endif

endmodule

// File: tb/tb_up_dn_cntr_param.sv
// Bench for up_dn_cntr_param (decade config): directed literal checks
// plus randomized stimulus checked every cycle against a behavioural model.
module tb_up_dn_cntr_param;

  localparam int W    = 4;
  localparam int MAXV = 9;
  localparam int MINV = 0;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic         clk;
  logic         reset;
  logic         load_en;
  logic [W-1:0] load_data;
  logic         up_dnb;
  logic         start_stop_b;
  logic [1:0]   mode;
  logic [W-1:0] cnt;
  logic         tc;
  logic         running;
  logic         done;
`ifdef UP_DN_CNTR_WRAP_FLAG_EN
  logic         wrap_flag;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  int m_cnt  = 0;
  int m_st   = 0;
  int m_wrap = 0;

  up_dn_cntr_param #(
    .WIDTH  (W),
    .MAX_VAL(MAXV),
    .MIN_VAL(MINV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_data   (load_data),
    .up_dnb      (up_dnb),
    .start_stop_b(start_stop_b),
    .mode        (mode),
    .cnt         (cnt),
    .tc          (tc),
    .running     (running),
    .done        (done)
`ifdef UP_DN_CNTR_WRAP_FLAG_EN
    ,
    .wrap_flag   (wrap_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, from the behavioural rules.
  task automatic model_step();
    int  ld;
    bit  cnt_en;
    bit  wrapm;
    int  term;
    if (!reset) begin
      m_cnt  = MINV;
      m_st   = S_IDLE;
      m_wrap = 0;
      return;
    end
    ld     = int'(load_data);
    wrapm  = (mode == 2'b00) || (mode == 2'b11);
    term   = up_dnb ? MAXV : MINV;
    cnt_en = (m_st == S_RUN) && start_stop_b && !load_en;
    if (load_en) begin
      m_cnt  = (ld < MINV) ? MINV : ((ld > MAXV) ? MAXV : ld);
      m_wrap = 0;
    end else if (cnt_en) begin
      if (up_dnb && m_cnt < MAXV) m_cnt = m_cnt + 1;
      else if (!up_dnb && m_cnt > MINV) m_cnt = m_cnt - 1;
      else if (wrapm) begin
        m_cnt  = up_dnb ? MINV : MAXV;
        m_wrap = 1;
      end
    end
    case (m_st)
      S_IDLE: if (start_stop_b) m_st = S_RUN;
      S_RUN: begin
        if (!start_stop_b) m_st = S_IDLE;
        else if (cnt_en && mode == 2'b10 && m_cnt == term)
          m_st = S_DONE;
      end
      default: if (!start_stop_b || load_en) m_st = S_IDLE;
    endcase
  endtask

  task automatic tick(input logic r, input logic ld,
                      input logic [W-1:0] ldd, input logic ud,
                      input logic ss, input logic [1:0] md);
    reset        = r;
    load_en      = ld;
    load_data    = ldd;
    up_dnb       = ud;
    start_stop_b = ss;
    mode         = md;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare process: DUT vs model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cnt", 32'(cnt), 32'(m_cnt));
      chk("m_tc", 32'(tc),
          32'(up_dnb ? (m_cnt == MAXV) : (m_cnt == MINV)));
      chk("m_running", 32'(running), 32'(m_st == S_RUN));
      chk("m_done", 32'(done), 32'(m_st == S_DONE));
`ifdef UP_DN_CNTR_WRAP_FLAG_EN
      chk("m_wrap_flag", 32'(wrap_flag), 32'(m_wrap));
`endif
    end
  end

  initial begin
    reset        = 1'b0;
    load_en      = 1'b0;
    load_data    = '0;
    up_dnb       = 1'b1;
    start_stop_b = 1'b0;
    mode         = 2'b00;

    tick(0, 0, 0, 1, 0, 2'b00);
    chk_en = 1;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);

    // Decade wrap counting up.
    tick(1, 0, 0, 1, 1, 2'b00);
    chk("start_running", 32'(running), 1);
    chk("start_cnt", 32'(cnt), 0);
    for (int i = 1; i <= 10; i++) begin
      tick(1, 0, 0, 1, 1, 2'b00);
      chk("up_wrap_cnt", 32'(cnt), 32'(i % 10));
      if (i == 9) chk("tc_at_9", 32'(tc), 1);
    end
`ifdef UP_DN_CNTR_WRAP_FLAG_EN
    chk("wrap_flag_set", 32'(wrap_flag), 1);
    tick(1, 0, 0, 1, 1, 2'b00);
    chk("wrap_flag_sticky", 32'(wrap_flag), 1);
`endif

    // Saturate down after a load of 2.
    tick(1, 1, 2, 0, 1, 2'b01);
    chk("load2_cnt", 32'(cnt), 2);
`ifdef UP_DN_CNTR_WRAP_FLAG_EN
    chk("wrap_flag_clr", 32'(wrap_flag), 0);
`endif
    for (int j = 0; j < 4; j++) begin
      tick(1, 0, 0, 0, 1, 2'b01);
      chk("sat_dn_cnt", 32'(cnt), 32'((j < 2) ? 1 - j : 0));
    end
    chk("sat_tc", 32'(tc), 1);
    chk("sat_running", 32'(running), 1);

    // One-shot up from 7.
    tick(1, 1, 7, 1, 1, 2'b10);
    chk("os_load", 32'(cnt), 7);
    tick(1, 0, 0, 1, 1, 2'b10);
    chk("os_8", 32'(cnt), 8);
    tick(1, 0, 0, 1, 1, 2'b10);
    chk("os_9", 32'(cnt), 9);
    chk("os_done", 32'(done), 1);
    chk("os_not_run", 32'(running), 0);
    tick(1, 0, 0, 1, 1, 2'b10);
    chk("os_hold", 32'(cnt), 9);
    chk("os_done_hold", 32'(done), 1);
    tick(1, 0, 0, 1, 0, 2'b10);
    chk("os_idle_done", 32'(done), 0);

    // Clamped load, load beats count.
    tick(1, 1, 12, 1, 0, 2'b00);
    chk("clamp_12", 32'(cnt), 9);
    tick(1, 0, 0, 1, 1, 2'b00);
    tick(1, 1, 3, 1, 1, 2'b00);
    chk("load_no_inc", 32'(cnt), 3);
    tick(1, 0, 0, 1, 1, 2'b00);
    tick(1, 0, 0, 1, 1, 2'b00);
    chk("cnt_5", 32'(cnt), 5);
    tick(1, 0, 0, 1, 0, 2'b00);
    chk("stop_hold", 32'(cnt), 5);
    chk("stop_running", 32'(running), 0);
    tick(1, 0, 0, 1, 1, 2'b00);
    tick(1, 0, 0, 1, 1, 2'b00);
    chk("cnt_6", 32'(cnt), 6);
    tick(0, 0, 0, 1, 1, 2'b00);
    chk("midrun_rst_cnt", 32'(cnt), 0);
    chk("midrun_rst_run", 32'(running), 0);

    // One-shot started at terminal value.
    tick(1, 1, 9, 1, 0, 2'b10);
    tick(1, 0, 0, 1, 1, 2'b10);
    tick(1, 0, 0, 1, 1, 2'b10);
    chk("os_term_cnt", 32'(cnt), 9);
    chk("os_term_done", 32'(done), 1);
    tick(1, 1, 4, 1, 1, 2'b10);
    chk("done_load_cnt", 32'(cnt), 4);
    chk("done_load_idle", 32'(done), 0);

    // Randomized phase.
    for (int k = 0; k < 4000; k++) begin
      tick(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 7) == 0),
           W'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0) ? ~up_dnb : up_dnb,
           ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)));
    end

    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
